// File: rtl/obi_assoc_cache.sv
// obi_assoc_cache: N-way set-associative blocking OBI cache, write-through / no-write-allocate.
// Optional read hit/miss counters are built when OBI_CACHE_PERF_EN is defined.
module obi_assoc_cache #(
  parameter int unsigned CACHE_SIZE = 8192,
  parameter int unsigned LINE_SIZE  = 16,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [3:0]            cpu_be_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int unsigned WORDS  = LINE_SIZE / 4;
  localparam int unsigned SETS   = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int unsigned OFF_W  = $clog2(LINE_SIZE);
  localparam int unsigned WORD_W = $clog2(WORDS);
  localparam int unsigned SET_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_WIDTH - SET_W - OFF_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, RD_HIT, RF_REQ, RF_WAIT, WR_REQ, WR_WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [WORD_W-1:0]     cnt_q, cnt_d;
  logic                  flushPend_q, flushPend_d;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAY_W-1:0]      rr_q    [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][WORDS];

  logic [SET_W-1:0]      lookSet, setQ;
  logic [TAG_W-1:0]      lookTag, tagQ;
  logic [WORD_W-1:0]     wordQ;
  logic                  hit;
  logic [WAY_W-1:0]      hitWay, victim, rrNext;
  logic [DATA_WIDTH-1:0] rdWord;
  logic                  startRefill, fillWord, fillLast, writeMerge, flushAll, retIdle;
  logic                  unused_addr_bits;

  assign setQ    = addr_q[OFF_W +: SET_W];
  assign tagQ    = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign wordQ   = addr_q[2 +: WORD_W];
  // In IDLE the lookup follows the incoming request; afterwards it follows the latched one.
  assign lookSet = (state_q == IDLE) ? cpu_addr_i[OFF_W +: SET_W] : setQ;
  assign lookTag = (state_q == IDLE) ? cpu_addr_i[ADDR_WIDTH-1 -: TAG_W] : tagQ;
  assign rdWord  = data_q[setQ][way_q][wordQ];
  assign rrNext  = (rr_q[lookSet] == WAY_W'(WAYS - 1)) ? '0 : rr_q[lookSet] + WAY_W'(1);
  assign unused_addr_bits = ^addr_q[1:0];

  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lookSet][w] && (tag_q[lookSet][w] == lookTag)) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
    end
  end

  // Descending scan so the lowest-index invalid way wins; otherwise round-robin.
  always_comb begin
    victim = rr_q[lookSet];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[lookSet][w]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    way_d        = way_q;
    cnt_d        = cnt_q;
    flushPend_d  = flushPend_q;
    cpu_gnt_o    = 1'b0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'hF;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    startRefill  = 1'b0;
    fillWord     = 1'b0;
    fillLast     = 1'b0;
    writeMerge   = 1'b0;
    flushAll     = 1'b0;
    retIdle      = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_gnt_o = cpu_req_i && !flush_i;
        flushAll  = flush_i;
        if (cpu_gnt_o) begin
          addr_d  = cpu_addr_i;
          be_d    = cpu_be_i;
          wdata_d = cpu_wdata_i;
          if (cpu_we_i) begin
            state_d = WR_REQ;
          end else if (hit) begin
            state_d = RD_HIT;
            way_d   = hitWay;
          end else begin
            state_d     = RF_REQ;
            way_d       = victim;
            cnt_d       = '0;
            startRefill = 1'b1;
          end
        end
      end
      RD_HIT: begin
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o  = rdWord;
        retIdle      = 1'b1;
      end
      RF_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[ADDR_WIDTH-1:OFF_W], cnt_q, 2'b00};
        if (mem_gnt_i) state_d = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem_rvalid_i) begin
          fillWord = 1'b1;
          cnt_d    = cnt_q + WORD_W'(1);
          if (cnt_q == WORD_W'(WORDS - 1)) begin
            fillLast = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = RF_REQ;
          end
        end
      end
      RESP: begin
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o  = rdWord;
        retIdle      = 1'b1;
      end
      WR_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = be_q;
        mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_o = wdata_q;
        if (mem_gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_rvalid_i) begin
          cpu_rvalid_o = 1'b1;
          writeMerge   = hit;
          retIdle      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush seen outside IDLE waits until the current transaction has answered the CPU.
    if (retIdle) begin
      state_d     = IDLE;
      flushAll    = flushPend_q || flush_i;
      flushPend_d = 1'b0;
    end else if ((state_q != IDLE) && flush_i) begin
      flushPend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      way_q       <= '0;
      cnt_q       <= '0;
      flushPend_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      flushPend_q <= flushPend_d;
      if (flushAll) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else begin
        if (startRefill) begin
          valid_q[lookSet][victim] <= 1'b0;
          rr_q[lookSet]            <= rrNext;
        end
        if (fillLast) valid_q[setQ][way_q] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits alone decide whether they are meaningful.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fillWord) data_q[setQ][way_q][cnt_q] <= mem_rdata_i;
      if (fillLast) tag_q[setQ][way_q] <= tagQ;
      if (writeMerge) begin
        for (int b = 0; b < 4; b++) begin
          if (be_q[b]) data_q[setQ][hitWay][wordQ][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

`ifdef OBI_CACHE_PERF_EN
  logic [31:0] hitCnt_q, missCnt_q;
  logic        rdAccept;

  assign rdAccept = (state_q == IDLE) && cpu_gnt_o && !cpu_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else if (rdAccept) begin
      if (hit) hitCnt_q <= hitCnt_q + 32'd1;
      else     missCnt_q <= missCnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hitCnt_q;
  assign miss_cnt_o = missCnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_obi_assoc_cache.sv
// Self-checking bench for obi_assoc_cache with a zero-wait (optionally stalling) memory model.
// Counter expectations follow OBI_CACHE_PERF_EN.
module tb_obi_assoc_cache;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_be_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_gnt_o;
  logic        cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int          checks = 0;
  int          errors = 0;
  bit          stallEn = 1'b0;
  logic [31:0] expQ[$];
  logic [36:0] memLog[$];
  logic [31:0] memArr [logic [31:0]];

  obi_assoc_cache dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: grant decided mid-cycle, response one cycle after acceptance; every
  // accepted transaction is logged as {we, be, addr}.
  initial begin
    logic        acc, aWe;
    logic [3:0]  aBe;
    logic [31:0] aAddr, aWd, cur;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i = mem_req_o && !(stallEn && ($urandom_range(0, 2) == 0));
      acc   = mem_gnt_i;
      aWe   = mem_we_o;
      aBe   = mem_be_o;
      aAddr = mem_addr_o;
      aWd   = mem_wdata_o;
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (acc) begin
        memLog.push_back({aWe, aBe, aAddr});
        if (aWe) begin
          cur = memRead(aAddr);
          for (int b = 0; b < 4; b++) if (aBe[b]) cur[8*b +: 8] = aWd[8*b +: 8];
          memArr[aAddr] = cur;
        end else begin
          mem_rdata_i = memRead(aAddr);
        end
        mem_rvalid_i = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyReset();
    @(negedge clk_i);
    rst_i     = 1'b1;
    flush_i   = 1'b0;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One blocking CPU transaction; lat counts cycles from the grant cycle to rvalid.
  // flushAt pulses flush_i in that cycle after the grant (0 = never).
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wd, input int flushAt,
                               output logic [31:0] rd, output int lat, output logic tout);
    int n;
    tout = 1'b0;
    rd   = '0;
    lat  = 0;
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_be_i    = be;
    cpu_wdata_i = wd;
    #1;
    n = 0;
    while (!cpu_gnt_o) begin
      n++;
      if (n > 50) begin
        tout = 1'b1;
        break;
      end
      @(negedge clk_i);
      #1;
    end
    if (!tout) begin
      @(posedge clk_i);
      #1;
      cpu_req_i = 1'b0;
      cpu_we_i  = 1'b0;
      forever begin
        @(negedge clk_i);
        lat++;
        if (cpu_rvalid_o) break;
        if (lat >= 300) begin
          tout = 1'b1;
          break;
        end
        flush_i = (lat == flushAt);
      end
      flush_i = 1'b0;
      rd = cpu_rdata_o;
    end
    cpu_req_i = 1'b0;
    if (tout) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout addr %h got no response, required one", addr);
    end
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    checks++;
    if ({cpu_gnt_o, cpu_rvalid_o, mem_req_o, mem_we_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_strobes got %b required 0000", {cpu_gnt_o, cpu_rvalid_o, mem_req_o, mem_we_o});
    end
    checks++;
    if (mem_be_o !== 4'hF) begin
      errors++;
      $display("[TB] FAIL reset_mem_be got %h required f", mem_be_o);
    end
    checks++;
    if ({cpu_rdata_o, mem_addr_o, mem_wdata_o} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h %h %h required zeros", cpu_rdata_o, mem_addr_o, mem_wdata_o);
    end
    checks++;
    if ({hit_cnt_o, miss_cnt_o} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters got %0d %0d required 0 0", hit_cnt_o, miss_cnt_o);
    end
  endtask

  task automatic test_cold_read();
    logic [31:0] rd, exp;
    logic [36:0] e;
    int          lat;
    logic        tout;
    memArr[32'h1004] = 32'h1111_2222;
    memLog.delete();
    expQ.push_back(32'h1111_2222);
    applyStimulus(1'b0, 32'h1004, 4'hF, '0, 0, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL cold_data got %h required %h", rd, exp); end
    checks++;
    if (lat != 9) begin errors++; $display("[TB] FAIL cold_latency got %0d required 9", lat); end
    checks++;
    if (memLog.size() != 4) begin errors++; $display("[TB] FAIL cold_refill_count got %0d required 4", memLog.size()); end
    for (int i = 0; i < 4 && i < memLog.size(); i++) begin
      e = memLog[i];
      checks++;
      if (e !== {1'b0, 4'hF, 32'h1000 + 32'(4 * i)}) begin
        errors++;
        $display("[TB] FAIL cold_refill_addr%0d got %h required %h", i, e, {1'b0, 4'hF, 32'h1000 + 32'(4 * i)});
      end
    end
    memLog.delete();
    expQ.push_back(32'h1111_2222);
    applyStimulus(1'b0, 32'h1004, 4'hF, '0, 0, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp || lat != 1) begin
      errors++;
      $display("[TB] FAIL hit_repeat got %h lat %0d required %h lat 1", rd, lat, exp);
    end
    expQ.push_back(32'h5A5A_100C);
    applyStimulus(1'b0, 32'h100C, 4'hF, '0, 0, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp || lat != 1 || memLog.size() != 0) begin
      errors++;
      $display("[TB] FAIL hit_other_word got %h lat %0d traffic %0d required %h lat 1 traffic 0", rd, lat, memLog.size(), exp);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd, exp;
    int          lat;
    logic        tout;
    memLog.delete();
    applyStimulus(1'b1, 32'h1004, 4'b0011, 32'hDEAD_BEEF, 0, rd, lat, tout);
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL write_latency got %0d required 2", lat); end
    checks++;
    if (memLog.size() != 1 || memLog[0] !== {1'b1, 4'b0011, 32'h1004}) begin
      errors++;
      $display("[TB] FAIL write_hit_traffic got %0d entries required one write of be 3 to 1004", memLog.size());
    end
    checks++;
    if (memArr[32'h1004] !== 32'h1111_BEEF) begin
      errors++;
      $display("[TB] FAIL write_hit_memdata got %h required 1111beef", memArr[32'h1004]);
    end
    memLog.delete();
    expQ.push_back(32'h1111_BEEF);
    applyStimulus(1'b0, 32'h1004, 4'hF, '0, 0, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp || lat != 1 || memLog.size() != 0) begin
      errors++;
      $display("[TB] FAIL write_hit_merge got %h lat %0d traffic %0d required %h lat 1 traffic 0", rd, lat, memLog.size(), exp);
    end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd, exp;
    int          lat;
    logic        tout;
    memLog.delete();
    applyStimulus(1'b1, 32'h3000, 4'hF, 32'hCAFE_F00D, 0, rd, lat, tout);
    checks++;
    if (memLog.size() != 1 || memLog[0] !== {1'b1, 4'hF, 32'h3000}) begin
      errors++;
      $display("[TB] FAIL write_miss_traffic got %0d entries required one write to 3000", memLog.size());
    end
    memLog.delete();
    expQ.push_back(32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h3000, 4'hF, '0, 0, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp || lat != 9 || memLog.size() != 4) begin
      errors++;
      $display("[TB] FAIL write_no_allocate got %h lat %0d traffic %0d required %h lat 9 traffic 4", rd, lat, memLog.size(), exp);
    end
  endtask

  task automatic test_aliasing();
    logic [31:0] rd, exp;
    int          lat;
    logic        tout;
    logic [31:0] addrs[5];
    int          lats[5];
    addrs = '{32'h0000, 32'h1000, 32'h2000, 32'h0000, 32'h2000};
    lats  = '{9, 9, 9, 9, 1};
    applyReset();
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(memRead(addrs[i]));
      applyStimulus(1'b0, addrs[i], 4'hF, '0, 0, rd, lat, tout);
      exp = expQ.pop_front();
      checks++;
      if (rd !== exp || lat != lats[i]) begin
        errors++;
        $display("[TB] FAIL alias_step%0d addr %h got %h lat %0d required %h lat %0d", i, addrs[i], rd, lat, exp, lats[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd, exp;
    int          lat;
    logic        tout;
    applyReset();
    expQ.push_back(memRead(32'h1008));
    applyStimulus(1'b0, 32'h1008, 4'hF, '0, 2, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp || lat != 9) begin
      errors++;
      $display("[TB] FAIL flush_in_refill_data got %h lat %0d required %h lat 9", rd, lat, exp);
    end
    expQ.push_back(memRead(32'h1008));
    applyStimulus(1'b0, 32'h1008, 4'hF, '0, 0, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp || lat != 9) begin
      errors++;
      $display("[TB] FAIL flush_pending_miss got %h lat %0d required %h lat 9", rd, lat, exp);
    end
    @(negedge clk_i);
    flush_i    = 1'b1;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h1008;
    #1;
    checks++;
    if (cpu_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_gnt got %b required 0", cpu_gnt_o); end
    @(negedge clk_i);
    flush_i   = 1'b0;
    cpu_req_i = 1'b0;
    expQ.push_back(memRead(32'h1008));
    applyStimulus(1'b0, 32'h1008, 4'hF, '0, 0, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp || lat != 9) begin
      errors++;
      $display("[TB] FAIL flush_idle_miss got %h lat %0d required %h lat 9", rd, lat, exp);
    end
  endtask

  task automatic test_reset_midrefill();
    logic [31:0] rd, exp;
    int          lat, spurious;
    logic        tout;
    applyReset();
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h2040;
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    spurious = 0;
    if (cpu_rvalid_o) spurious++;
    repeat (4) begin
      @(negedge clk_i);
      if (cpu_rvalid_o || mem_req_o) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("[TB] FAIL reset_abandon got %0d active cycles required 0", spurious); end
    expQ.push_back(memRead(32'h2040));
    applyStimulus(1'b0, 32'h2040, 4'hF, '0, 0, rd, lat, tout);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp || lat != 9) begin
      errors++;
      $display("[TB] FAIL reset_then_miss got %h lat %0d required %h lat 9", rd, lat, exp);
    end
  endtask

  task automatic test_counters();
    logic [31:0] rd, exp, expHit, expMiss;
    int          lat;
    logic        tout;
    logic [31:0] addrs[5];
    addrs = '{32'h4000, 32'h4000, 32'h4004, 32'h5000, 32'h4008};
    applyReset();
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(memRead(addrs[i]));
      applyStimulus(1'b0, addrs[i], 4'hF, '0, 0, rd, lat, tout);
      exp = expQ.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("[TB] FAIL count_read%0d got %h required %h", i, rd, exp); end
    end
    applyStimulus(1'b1, 32'h4000, 4'hF, 32'h0BAD_CAFE, 0, rd, lat, tout);
`ifdef OBI_CACHE_PERF_EN
    expHit  = 32'd3;
    expMiss = 32'd2;
`else
    expHit  = 32'd0;
    expMiss = 32'd0;
`endif
    #1;
    checks++;
    if (hit_cnt_o !== expHit) begin errors++; $display("[TB] FAIL hit_count got %0d required %0d", hit_cnt_o, expHit); end
    checks++;
    if (miss_cnt_o !== expMiss) begin errors++; $display("[TB] FAIL miss_count got %0d required %0d", miss_cnt_o, expMiss); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp, addr, wd;
    logic [31:0] bases[3];
    logic [3:0]  be;
    int          lat;
    logic        tout;
    bases = '{32'h6000, 32'h7000, 32'h8000};
    applyReset();
    stallEn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      addr = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 3)) * 32'd4;
      if ($urandom_range(0, 3) == 0) begin
        be = 4'($urandom_range(1, 15));
        wd = $urandom;
        applyStimulus(1'b1, addr, be, wd, 0, rd, lat, tout);
      end else begin
        expQ.push_back(memRead(addr));
        applyStimulus(1'b0, addr, 4'hF, '0, 0, rd, lat, tout);
        exp = expQ.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("[TB] FAIL b2b_read%0d addr %h got %h required %h", i, addr, rd, exp); end
      end
    end
    stallEn = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_be_i    = 4'h0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    $display("[TB] obi_assoc_cache bench start");
    test_reset();
    test_cold_read();
    test_write_hit();
    test_write_miss();
    test_aliasing();
    test_flush();
    test_reset_midrefill();
    test_counters();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_assoc_cache.md
# obi_assoc_cache

Parametrised N-way set-associative blocking cache between the CV32E40X OBI data (or instruction) port and the memory-side OBI fabric. Read misses trigger a full line refill with per-set round-robin replacement. Writes are write-through, no-write-allocate; write hits also update the cached word under byte enables. A flush input invalidates the whole cache in one cycle.

## Interface
Parameters:
- CACHE_SIZE, 8192: total data capacity in bytes; power of two.
- LINE_SIZE, 16: line size in bytes; power of two, ≥ 8.
- WAYS, 2: associativity; power of two, 1..8. 1 gives a direct-mapped cache.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width. Fixed at 32 so the 4-bit byte enable holds.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  invalidate all lines; single-cycle pulse.
- cpu_req_i, cpu_we_i, cpu_be_i[3:0], cpu_addr_i, cpu_wdata_i  in  OBI slave request.
- cpu_gnt_o  out  1, cpu_rvalid_o  out  1, cpu_rdata_o  out  32  OBI slave response.
- mem_req_o, mem_we_o, mem_be_o[3:0], mem_addr_o, mem_wdata_o  out  OBI master request.
- mem_gnt_i  in  1, mem_rvalid_i  in  1, mem_rdata_i  in  32  OBI master response.
- hit_cnt_o  out  32  read-hit counter.
- miss_cnt_o  out  32  read-miss counter.

## Operation
Address fields and sizes:
- Address split: tag | set | word | byte. SETS = CACHE_SIZE/(LINE_SIZE·WAYS). Bits [1:0] are ignored.
- Storage per set and way: valid bit, tag, LINE_SIZE/4 words. Per set: a log2(WAYS)-bit round-robin pointer.

State machine (state names IDLE, RD_HIT, RF_REQ, RF_WAIT, WR_REQ, WR_WAIT, RESP):
- IDLE: cpu_gnt_o = cpu_req_i. On an accepted request, latch addr, be, wdata and we.
  - Read hit goes to RD_HIT.
  - Read miss goes to RF_REQ.
  - Write goes to WR_REQ.
- RD_HIT: cpu_rvalid_o = 1 with the hit word. Return to IDLE.
- Victim selection on a miss: lowest-index invalid way; if no way is invalid, use the set's pointer.
  - The victim's valid bit is cleared when leaving IDLE, so a partial line never hits.
  - The pointer increments mod WAYS when the refill starts.
- RF_REQ: mem_req_o = 1, mem_we_o = 0, mem_be_o = 4'hF. Address is line base + 4·cnt, with cnt starting at 0. On mem_gnt_i go to RF_WAIT.
- RF_WAIT: on mem_rvalid_i, write the word into the victim way and increment cnt.
  - If this was the last word: set valid and tag, go to RESP.
  - Otherwise go to RF_REQ.
- RESP: cpu_rvalid_o = 1, cpu_rdata_o = requested word read from the array. Return to IDLE.
- WR_REQ: mem_req_o = mem_we_o = 1 with the latched addr, be and wdata. On mem_gnt_i go to WR_WAIT.
- WR_WAIT: on mem_rvalid_i, cpu_rvalid_o = 1 in the same cycle. If the write hit, merge wdata into the hit way under be. Return to IDLE. A write miss allocates nothing.
- Hit logic: at most one way may match. Multiple matches are impossible by construction.

Flush:
- In IDLE: clears all valid bits in the next cycle. cpu_gnt_o = 0 in the flush cycle.
- In any other state: flush is recorded as pending and applied on the return to IDLE. A refill in progress completes its CPU response, but its line is then invalidated.

## Timing
Reset:
- rst_i clears state to IDLE, all valid bits, round-robin pointers, cnt, pending flush and both counters.
- All outputs are 0 after reset, except mem_be_o = 4'hF. cpu_rdata_o and mem_addr_o are 0.
- Reset mid-refill or mid-write abandons the transaction. No response is produced, and a late mem_rvalid_i is ignored.

Latency:
- Read hit: gnt in cycle 0, rvalid in cycle 1.
- Read miss: rvalid one cycle after the last refill rvalid. With zero-wait memory (gnt same cycle, rvalid next cycle), total is 2·(LINE_SIZE/4)+1 cycles after gnt.
- Write: cpu_rvalid_o in the same cycle as mem_rvalid_i.

Handshake and stall rules:
- mem_* request fields are held stable while mem_req_o = 1 and mem_gnt_i = 0.
- Only one memory transaction is outstanding at a time.
- cpu_gnt_o = 0 in every state except IDLE.

## Configuration
- OBI_CACHE_PERF_EN defined: hit_cnt_o increments on each read hit and miss_cnt_o on each read miss. Increments happen on the IDLE decision cycle. Both counters wrap at 2^32. Writes are not counted.
- OBI_CACHE_PERF_EN undefined: counter logic is absent and both outputs are tied to 0.

## Test plan
- Cold read of 0x0000_1004 (WAYS=2, LINE=16): memory sees reads 0x1000, 0x1004, 0x1008, 0x100C. CPU gets the word at 0x1004. A repeat read hits with rvalid in cycle 1.
- Aliasing, 2-way, 8 KB: fill 0x0000, 0x1000 and 0x2000 (same set), then read 0x0000.
  - Expect a miss on 0x0000 (way 0 was evicted).
  - Expect a hit on 0x2000.
- Write with be = 4'b0011, data 0xDEAD_BEEF, to a cached 0x1004 holding 0x1111_2222: memory write is issued; a later read returns 0x1111_BEEF with no memory traffic.
- Write miss to 0x3000: one memory write is issued. A subsequent read of 0x3000 misses and refills.
- Flush asserted during RF_WAIT: the CPU still gets correct data. The next read of the same address misses.
- With OBI_CACHE_PERF_EN: 3 hits and 2 misses give hit_cnt_o = 3 and miss_cnt_o = 2. Without the macro, both outputs stay 0.
